// File: rtl/parser_pkg.sv
// Shared types and constants for the result-to-ASCII emitter.
package parser_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_EMIT_DIGIT,
        S_EMIT_ERR,
        S_EMIT_EOL,
        S_DONE
    } state_t;

    localparam int NUM_DIGITS = 10;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    localparam logic [6:0] ZERO = 7'h30;
    localparam logic [6:0] E    = 7'h45;
    localparam logic [6:0] R    = 7'h52;

    // Pick one BCD digit out of the packed digit vector (digit 0 = least significant).
    function automatic logic [3:0] bcd_digit(input logic [BCD_W-1:0] bcd, input logic [3:0] idx);
        bcd_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 4'(i)) bcd_digit = bcd[i*4 +: 4];
        end
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble: 32-bit binary to 10 BCD digits, one bit per cycle.
// The start cycle loads the operand and already shifts in its MSB, so the
// register evolves through cycles T+1..T+32 and is final (done=1) in T+32.
module bin2bcd_iter
    import parser_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done
);

    logic [31:0]      shreg;
    logic [5:0]       cnt;
    logic             active;
    logic [BCD_W-1:0] adj;

    // Add-3 correction on every digit that is 5 or more, ahead of the shift.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    // Load on start, then one correct-and-shift step per cycle until 32 bits are in.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg  <= '0;
            bcd    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            shreg  <= {bin[30:0], 1'b0};
            bcd    <= {{(BCD_W-1){1'b0}}, bin[31]};
            cnt    <= 6'd1;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == 6'd32) begin
                active <= 1'b0;
            end else begin
                bcd   <= {adj[BCD_W-2:0], shreg[31]};
                shreg <= {shreg[30:0], 1'b0};
                cnt   <= cnt + 6'd1;
            end
        end
    end

    assign done = active && (cnt == 6'd32);

endmodule

// File: rtl/result_ascii_emitter.sv
// Turns a parser result into an ASCII decimal line (or "ERR") on a
// valid/ready character stream, once per reset.
// Handshake: a character transfers on a rising clk edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low,
// out_char and out_valid hold their values until that transfer happens.
module result_ascii_emitter
    import parser_pkg::*;
#(
    parameter logic [6:0] EOL_CHAR = 7'h0A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] p,
    input  logic        parsing_done,
    input  logic        error_flag,
    output logic [6:0]  out_char,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        emit_done
);

    state_t           state_q, state_n;
    logic [3:0]       digit_idx, idx_n;
    logic [3:0]       ms_idx;
    logic             pd_q, ef_q, armed;
    logic             val_edge, err_edge;
    logic             conv_start, conv_done;
    logic [BCD_W-1:0] bcd;
    logic             handshake;

    bin2bcd_iter u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (p),
        .bcd   (bcd),
        .done  (conv_done)
    );

    // Edge detectors; armed blocks the first post-reset cycle so a level
    // that was already high is not mistaken for a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pd_q  <= 1'b0;
            ef_q  <= 1'b0;
            armed <= 1'b0;
        end else begin
            pd_q  <= parsing_done;
            ef_q  <= error_flag;
            armed <= 1'b1;
        end
    end

    assign val_edge  = armed && parsing_done && !pd_q;
    assign err_edge  = armed && error_flag && !ef_q;
    assign handshake = out_valid && out_ready;

    // Priority encoder: most-significant non-zero digit, 0 when the value is 0.
    always_comb begin
        ms_idx = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[i*4 +: 4] != 4'd0) ms_idx = 4'(i);
        end
    end

    // State and digit/letter index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            digit_idx <= 4'd0;
        end else begin
            state_q   <= state_n;
            digit_idx <= idx_n;
        end
    end

    // Next-state, character selection and handshake progression.
    always_comb begin
        state_n    = state_q;
        idx_n      = digit_idx;
        out_valid  = 1'b0;
        out_char   = 7'h00;
        conv_start = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (err_edge) begin
                    state_n = S_EMIT_ERR;
                    idx_n   = 4'd2;
                end else if (val_edge) begin
                    state_n    = S_CONVERT;
                    conv_start = 1'b1;
                end
            end
            S_CONVERT: begin
                if (conv_done) begin
                    state_n = S_EMIT_DIGIT;
                    idx_n   = ms_idx;
                end
            end
            S_EMIT_DIGIT: begin
                out_valid = 1'b1;
                out_char  = ZERO + {3'b000, bcd_digit(bcd, digit_idx)};
                if (handshake) begin
                    if (digit_idx == 4'd0) state_n = S_EMIT_EOL;
                    else                   idx_n   = digit_idx - 4'd1;
                end
            end
            S_EMIT_ERR: begin
                out_valid = 1'b1;
                out_char  = (digit_idx == 4'd2) ? E : R;
                if (handshake) begin
                    if (digit_idx == 4'd0) state_n = S_EMIT_EOL;
                    else                   idx_n   = digit_idx - 4'd1;
                end
            end
            S_EMIT_EOL: begin
                out_valid = 1'b1;
                out_char  = EOL_CHAR;
                if (handshake) state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_DONE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign emit_done = (state_q == S_DONE);

endmodule

// File: tb/tb_result_ascii_emitter.sv
// Directed bench for result_ascii_emitter: value, error, stall and reset scenarios.
module tb_result_ascii_emitter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] p = '0;
    logic        parsing_done = 1'b0;
    logic        error_flag = 1'b0;
    logic [6:0]  out_char;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        emit_done;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] exp_q[$];
    logic [6:0] act_q[$];
    int         act_cyc[$];

    result_ascii_emitter #(.EOL_CHAR(7'h0A)) dut (
        .clk          (clk),
        .rst          (rst),
        .p            (p),
        .parsing_done (parsing_done),
        .error_flag   (error_flag),
        .out_char     (out_char),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .emit_done    (emit_done)
    );

    // Clock
    always #5 clk = ~clk;

    // Reset with all inputs low, leaving a couple of idle cycles afterwards.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; parsing_done = 1'b0; error_flag = 1'b0; out_ready = 1'b1; p = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Expected line: the text characters followed by a line feed.
    task automatic build_exp(input string s);
        byte b;
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            exp_q.push_back(b[6:0]);
        end
        exp_q.push_back(7'h0A);
    endtask

    // Record transferred characters and their cycle numbers, bounded by budget.
    task automatic capture(input int n, input int budget, output int first_cyc);
        int cyc;
        cyc = 0;
        first_cyc = -1;
        act_q.delete();
        act_cyc.delete();
        while (cyc < budget && act_q.size() < n) begin
            @(negedge clk);
            cyc++;
            if (out_valid === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (out_ready === 1'b1) begin
                    act_q.push_back(out_char);
                    act_cyc.push_back(cyc);
                end
            end
        end
    endtask

    task automatic test_reset();
        int vcnt;
        @(negedge clk);
        rst = 1'b1; parsing_done = 1'b1; error_flag = 1'b0; out_ready = 1'b1; p = 32'd5;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_vec++; if (out_char !== 7'h00) begin n_err++; $display("FAIL reset_char: got %h want 00", out_char); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (emit_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", emit_done); end
        vcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) vcnt++;
        end
        n_vec++; if (vcnt !== 0) begin n_err++; $display("FAIL reset_level_no_trigger: got %0d active cycles want 0", vcnt); end
    endtask

    task automatic test_value(input logic [31:0] pv, input string s, input string name);
        int first;
        int span;
        int vcnt;
        do_reset();
        build_exp(s);
        p = pv;
        parsing_done = 1'b1;
        capture(exp_q.size(), 80, first);
        n_vec++; if (first !== 33) begin n_err++; $display("FAIL %s first_valid_cycle: got %0d want 33", name, first); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= act_q.size()) begin
                n_err++; $display("FAIL %s char%0d: got none want %h", name, i, exp_q[i]);
            end else if (act_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL %s char%0d: got %h want %h", name, i, act_q[i], exp_q[i]);
            end
        end
        span = (act_q.size() > 0) ? (act_cyc[act_cyc.size()-1] - act_cyc[0] + 1) : 0;
        n_vec++; if (span !== exp_q.size()) begin n_err++; $display("FAIL %s back_to_back_span: got %0d want %0d", name, span, exp_q.size()); end
        @(negedge clk);
        n_vec++; if (emit_done !== 1'b1) begin n_err++; $display("FAIL %s emit_done: got %b want 1", name, emit_done); end
        n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL %s done_idle: got busy=%b valid=%b want 0/0", name, busy, out_valid); end
        parsing_done = 1'b0;
        @(negedge clk);
        parsing_done = 1'b1; error_flag = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || emit_done !== 1'b1) vcnt++;
        end
        n_vec++; if (vcnt !== 0) begin n_err++; $display("FAIL %s done_ignores_inputs: got %0d bad cycles want 0", name, vcnt); end
    endtask

    task automatic test_error();
        int first;
        do_reset();
        build_exp("ERR");
        p = 32'd7;
        parsing_done = 1'b1; error_flag = 1'b1;
        capture(exp_q.size() + 1, 20, first);
        n_vec++; if (first !== 1) begin n_err++; $display("FAIL err first_valid_cycle: got %0d want 1", first); end
        n_vec++; if (act_q.size() !== exp_q.size()) begin n_err++; $display("FAIL err char_count: got %0d want %0d", act_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= act_q.size()) begin
                n_err++; $display("FAIL err char%0d: got none want %h", i, exp_q[i]);
            end else if (act_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL err char%0d: got %h want %h", i, act_q[i], exp_q[i]);
            end
        end
        n_vec++; if (emit_done !== 1'b1) begin n_err++; $display("FAIL err emit_done: got %b want 1", emit_done); end
    endtask

    task automatic test_stall();
        int cyc;
        int first;
        do_reset();
        out_ready = 1'b0;
        p = 32'd56;
        parsing_done = 1'b1;
        cyc = 0;
        while (cyc < 40 && out_valid !== 1'b1) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++; if (cyc !== 33) begin n_err++; $display("FAIL stall first_valid_cycle: got %0d want 33", cyc); end
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_char !== 7'h35) begin
                n_err++; $display("FAIL stall hold%0d: got valid=%b char=%h want 1/35", k, out_valid, out_char);
            end
            if (k < 4) @(negedge clk);
        end
        out_ready = 1'b1;
        capture(2, 10, first);
        n_vec++; if (first !== 1) begin n_err++; $display("FAIL stall resume_cycle: got %0d want 1", first); end
        n_vec++; if (act_q.size() < 1 || act_q[0] !== 7'h36) begin n_err++; $display("FAIL stall second_char: got %h want 36", (act_q.size() > 0) ? act_q[0] : 7'h00); end
        n_vec++; if (act_q.size() < 2 || act_q[1] !== 7'h0A) begin n_err++; $display("FAIL stall eol: got %h want 0a", (act_q.size() > 1) ? act_q[1] : 7'h00); end
    endtask

    task automatic test_reset_mid();
        int first;
        int vcnt;
        do_reset();
        p = 32'd987;
        parsing_done = 1'b1;
        capture(2, 50, first);
        n_vec++; if (act_q.size() !== 2 || act_q[0] !== 7'h39 || act_q[1] !== 7'h38) begin
            n_err++; $display("FAIL rstmid prefix: got %0d chars want 9,8 offered", act_q.size());
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid valid: got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0 || emit_done !== 1'b0 || out_char !== 7'h00) begin
            n_err++; $display("FAIL rstmid idle: got busy=%b done=%b char=%h want 0/0/00", busy, emit_done, out_char);
        end
        vcnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) vcnt++;
        end
        n_vec++; if (vcnt !== 0) begin n_err++; $display("FAIL rstmid no_continuation: got %0d active cycles want 0", vcnt); end
        parsing_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        build_exp("987");
        parsing_done = 1'b1;
        capture(exp_q.size(), 80, first);
        n_vec++; if (first !== 33) begin n_err++; $display("FAIL rstmid first_valid_cycle: got %0d want 33", first); end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (i >= act_q.size()) begin
                n_err++; $display("FAIL rstmid char%0d: got none want %h", i, exp_q[i]);
            end else if (act_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL rstmid char%0d: got %h want %h", i, act_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_value(32'd0, "0", "zero");
        test_value(32'd1234, "1234", "v1234");
        test_value(32'hFFFF_FFFF, "4294967295", "max");
        test_value(32'd1000000000, "1000000000", "v1e9");
        test_error();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/result_ascii_emitter.md
RESULT_ASCII_EMITTER -- requirements
Module: result_ascii_emitter

Interface
REQ-001 SHALL have parameter EOL_CHAR, default 7'h0A, the line terminator appended after every result string.
REQ-002 SHALL have port clk  input  1  the single rising-edge clock for the block.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port p  input  32  unsigned result from the upstream parser.
REQ-005 SHALL have port parsing_done  input  1  level, sticky until parser reset; marks p as valid.
REQ-006 SHALL have port error_flag  input  1  level, sticky; marks a parse error.
REQ-007 SHALL have port out_char  output  7  ASCII character being offered.
REQ-008 SHALL have port out_valid  output  1  out_char is valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_char this cycle.
REQ-010 SHALL have port busy  output  1  high from trigger through the last handshake.
REQ-011 SHALL have port emit_done  output  1  sticky; the full string has been transferred.

Function
REQ-012 SHALL register parsing_done and error_flag each cycle and define the trigger as a 0->1 transition on either input, with the inputs sampled in IDLE only.
REQ-013 SHALL capture p into an internal 32-bit register in the trigger cycle T.
REQ-014 SHALL select the error path when error_flag rises in cycle T, including when both inputs rise in the same cycle.
REQ-015 SHALL use the states IDLE, CONVERT, EMIT_DIGIT, EMIT_ERR, EMIT_EOL and DONE, with one-hot or binary encoding left free.
REQ-016 SHALL transition from IDLE to CONVERT on a value trigger, and from IDLE to EMIT_ERR on an error trigger.
REQ-017 SHALL perform in CONVERT an iterative double-dabble over exactly 32 cycles (T+1..T+32) into 10 BCD digits (40 bits), with digit values never exceeding 9.
REQ-018 SHALL locate the most-significant non-zero digit with a combinational priority encoder at the end of CONVERT, and SHALL emit a single "0" when p==0.
REQ-019 SHALL assert out_valid with the first digit in cycle T+33 on the value path, and in cycle T+1 with "E" on the error path.
REQ-020 SHALL emit in EMIT_DIGIT the digits MS-first as 7'h30+digit, advancing one digit per handshake (out_valid && out_ready), then go to EMIT_EOL.
REQ-021 SHALL emit in EMIT_ERR "E","R","R" (7'h45, 7'h52, 7'h52), one per handshake, then go to EMIT_EOL.
REQ-022 SHALL offer EOL_CHAR in EMIT_EOL and go to DONE on its handshake.
REQ-023 SHALL hold out_char and out_valid stable while out_valid && !out_ready, and SHALL NOT deassert out_valid before the handshake completes.
REQ-024 SHALL never present out_valid while in IDLE, CONVERT or DONE.
REQ-025 SHALL permit back-to-back handshakes at one character per cycle when out_ready is held high.
REQ-026 SHALL in DONE hold emit_done=1 and busy=0, and ignore all inputs until rst.
REQ-027 SHALL ignore input transitions occurring while busy (no queuing).

Reset
REQ-028 SHALL on rst=1 at a clock edge return to IDLE and clear out_valid, busy, emit_done, the BCD register, the digit index and the edge-detect registers, with out_char=7'h00, effective the following cycle.
REQ-029 SHALL on reset mid-CONVERT or mid-emission abort the string without completing the pending character, and SHALL give no partial continuation after reset.
REQ-030 SHALL NOT trigger if parsing_done is already high in the first cycle after reset; a trigger requires a 0->1 edge observed after reset.

Structure
REQ-031 SHALL place the state enum, ASCII constants (ZERO=7'h30, E, R) and NUM_DIGITS=10 in shared package parser_pkg.
REQ-032 SHALL implement the double-dabble engine as sub-module bin2bcd_iter, with ports start, bin[31:0], bcd[39:0] and done, taking 32 cycles.
REQ-033 SHALL keep the FSM, digit index, priority encoder and handshake logic in result_ascii_emitter.

Verification
REQ-034 SHALL cover: p=0, parsing_done rises at T, out_ready=1 -> "0", 7'h0A; first out_valid at T+33.
REQ-035 SHALL cover: p=1234, out_ready=1 -> "1","2","3","4",7'h0A on consecutive cycles, then emit_done=1.
REQ-036 SHALL cover: p=32'hFFFFFFFF -> "4294967295",7'h0A, i.e. 11 characters with no leading zero suppressed wrongly.
REQ-037 SHALL cover: error_flag and parsing_done rise in the same cycle with p=7 -> "E","R","R",7'h0A only.
REQ-038 SHALL cover: p=56, out_ready low for 5 cycles while "5" is offered -> "5" is held stable and is followed by "6" only after out_ready returns high.
REQ-039 SHALL cover: rst during the second character of p=987 -> out_valid=0 next cycle, IDLE; a fresh parsing_done edge then yields "987",7'h0A.
